// File: rtl/dcache_wb_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Serves 32-bit loads/stores from 2^IDX_W lines of 512 bits, stalls the
// pipeline on misses and moves whole lines to/from memory.
//
// Memory handshake: a transaction is open while mem_req is high; mem_we,
// mem_addr and mem_wdata are registered and held unchanged from the cycle
// mem_req rises until the cycle mem_ack is seen. mem_ack completes the
// transaction in that same cycle (read data valid alongside it) and is
// ignored whenever mem_req is low. mem_req always drops for at least one
// cycle between two transactions.
module dcache_wb_ctrl #(
    parameter int IDX_W = 3,
    parameter int TAG_W = 32 - 6 - IDX_W
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         MemRead,
    input  logic         MemWrite,
    input  logic [31:0]  Addr,
    input  logic [31:0]  WData,
    output logic [31:0]  RData,
    output logic         Stall,
    input  logic         Flush,
    output logic         FlushDone,
    output logic         mem_req,
    output logic         mem_we,
    output logic [25:0]  mem_addr,
    output logic [511:0] mem_wdata,
    input  logic [511:0] mem_rdata,
    input  logic         mem_ack,
    output logic [2:0]   dbg_state
);

    localparam int LINES = 1 << IDX_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB      = 3'd1,
        FILL    = 3'd2,
        FL_SCAN = 3'd3,
        FL_WB   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [LINES-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]   tag_q [LINES];
    logic [TAG_W-1:0]   tag_d [LINES];
    logic [511:0]       data_q [LINES];
    logic [511:0]       data_d [LINES];
    logic [IDX_W-1:0]   fl_cnt_q, fl_cnt_d;
    logic               flush_done_q, flush_done_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [25:0]        mem_addr_q, mem_addr_d;
    logic [511:0]       mem_wdata_q, mem_wdata_d;

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [8:0]         woff;
    logic               access;
    logic               hit;
    logic               ack;
    logic               unused_addr_bits;

    assign idx    = Addr[5+IDX_W:6];
    assign tag    = Addr[31:6+IDX_W];
    assign woff   = {Addr[5:2], 5'b0};
    assign access = MemRead | MemWrite;
    assign hit    = valid_q[idx] && (tag_q[idx] == tag);
    assign ack    = mem_ack && mem_req_q;

    assign unused_addr_bits = ^Addr[1:0];

    assign FlushDone = flush_done_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign dbg_state = state_q;

    // Next-state, line-array updates, memory launch and pipeline outputs.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        tag_d        = tag_q;
        data_d       = data_q;
        fl_cnt_d     = fl_cnt_q;
        flush_done_d = 1'b0;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        RData        = '0;
        Stall        = 1'b0;

        case (state_q)
            IDLE: begin
                if (access) begin
                    if (hit) begin
                        // A simultaneous read+write is a store.
                        if (MemWrite) begin
                            data_d[idx][woff +: 32] = WData;
                            dirty_d[idx]            = 1'b1;
                        end else begin
                            RData = data_q[idx][woff +: 32];
                        end
                    end else begin
                        Stall     = 1'b1;
                        mem_req_d = 1'b1;
                        if (valid_q[idx] && dirty_q[idx]) begin
                            state_d     = WB;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = {tag_q[idx], idx};
                            mem_wdata_d = data_q[idx];
                        end else begin
                            state_d     = FILL;
                            mem_we_d    = 1'b0;
                            mem_addr_d  = Addr[31:6];
                            mem_wdata_d = '0;
                        end
                    end
                end else if (Flush) begin
                    state_d  = FL_SCAN;
                    fl_cnt_d = '0;
                end
            end

            WB: begin
                Stall = 1'b1;
                if (ack) begin
                    dirty_d[idx] = 1'b0;
                    mem_req_d    = 1'b0;
                    state_d      = FILL;
                end
            end

            FILL: begin
                Stall = 1'b1;
                // Entered from WB with mem_req low: launch the read here.
                if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = Addr[31:6];
                    mem_wdata_d = '0;
                end else if (ack) begin
                    data_d[idx]  = mem_rdata;
                    tag_d[idx]   = tag;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    mem_req_d    = 1'b0;
                    state_d      = IDLE;
                end
            end

            FL_SCAN: begin
                Stall = 1'b1;
                if (dirty_q[fl_cnt_q]) begin
                    state_d = FL_WB;
                end else if (&fl_cnt_q) begin
                    flush_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    fl_cnt_d = fl_cnt_q + IDX_W'(1);
                end
            end

            FL_WB: begin
                Stall = 1'b1;
                // First cycle loads the holding registers from the scanned line.
                if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {tag_q[fl_cnt_q], fl_cnt_q};
                    mem_wdata_d = data_q[fl_cnt_q];
                end else if (ack) begin
                    dirty_d[fl_cnt_q] = 1'b0;
                    mem_req_d         = 1'b0;
                    if (&fl_cnt_q) begin
                        flush_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        fl_cnt_d = fl_cnt_q + IDX_W'(1);
                        state_d  = FL_SCAN;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Control state and memory-port registers, cleared by reset.
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            fl_cnt_q     <= '0;
            flush_done_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            fl_cnt_q     <= fl_cnt_d;
            flush_done_q <= flush_done_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Tag and data storage; contents are meaningless until valid is set.
    always_ff @(posedge CLK) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_dcache_wb_ctrl.sv
// Self-checking bench for dcache_wb_ctrl: directed scenarios followed by a
// randomized access/flush mix, checked against a word-level memory model.
module tb_dcache_wb_ctrl;

    localparam int IDX_W = 3;
    localparam int LINES = 1 << IDX_W;
    localparam int TXW   = 1 + 26 + 512;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         CLR = 1'b0;
    logic         MemRead = 1'b0;
    logic         MemWrite = 1'b0;
    logic [31:0]  Addr = '0;
    logic [31:0]  WData = '0;
    logic         Flush = 1'b0;
    logic [511:0] mem_rdata = '0;
    logic         mem_ack = 1'b0;
    logic [31:0]  RData;
    logic         Stall;
    logic         FlushDone;
    logic         mem_req;
    logic         mem_we;
    logic [25:0]  mem_addr;
    logic [511:0] mem_wdata;
    logic [2:0]   dbg_state;

    always #5 clk = ~clk;

    dcache_wb_ctrl #(.IDX_W(IDX_W)) dut (
        .CLK(clk), .CLR(CLR), .MemRead(MemRead), .MemWrite(MemWrite),
        .Addr(Addr), .WData(WData), .RData(RData), .Stall(Stall),
        .Flush(Flush), .FlushDone(FlushDone), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    int ack_lat = 2;
    logic [TXW-1:0] exp_q[$];
    logic [TXW-1:0] act_q[$];

    // Backing memory seen by the DUT (line granularity).
    logic [511:0] mem_lines [logic [25:0]];

    // Reference model: architectural word values, expected memory image,
    // and which line each index holds.
    logic [31:0] gold    [logic [29:0]];
    logic [31:0] ref_mem [logic [29:0]];
    bit          res_valid [LINES];
    bit          res_dirty [LINES];
    logic [25:0] res_line  [LINES];

    task automatic check(input string tag, input logic [TXW-1:0] obs, input logic [TXW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [29:0] wa);
        return (32'(wa) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] ref_word(input logic [29:0] wa);
        if (ref_mem.exists(wa)) return ref_mem[wa];
        return init_word(wa);
    endfunction

    function automatic logic [31:0] gold_word(input logic [29:0] wa);
        if (gold.exists(wa)) return gold[wa];
        return ref_word(wa);
    endfunction

    function automatic logic [511:0] gold_line(input logic [25:0] ln);
        logic [511:0] r;
        for (int w = 0; w < 16; w++) r[w*32 +: 32] = gold_word({ln, 4'(w)});
        return r;
    endfunction

    function automatic logic [511:0] mem_line_read(input logic [25:0] ln);
        logic [511:0] r;
        if (mem_lines.exists(ln)) return mem_lines[ln];
        for (int w = 0; w < 16; w++) r[w*32 +: 32] = init_word({ln, 4'(w)});
        return r;
    endfunction

    task automatic model_write_back(input int ix);
        for (int w = 0; w < 16; w++) begin
            ref_mem[{res_line[ix], 4'(w)}] = gold_word({res_line[ix], 4'(w)});
        end
        res_dirty[ix] = 1'b0;
    endtask

    // Reset invalidates everything; stores sitting in dirty lines are lost.
    task automatic model_reset();
        for (int ix = 0; ix < LINES; ix++) begin
            if (res_valid[ix] && res_dirty[ix]) begin
                for (int w = 0; w < 16; w++) gold.delete({res_line[ix], 4'(w)});
            end
            res_valid[ix] = 1'b0;
            res_dirty[ix] = 1'b0;
        end
    endtask

    task automatic check_txns(input string tag);
        check({tag, "_txn_cnt"}, act_q.size(), exp_q.size());
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            check({tag, "_txn"}, act_q.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        act_q.delete();
    endtask

    // ---------------- memory responder ----------------
    int             req_cyc = 0;
    logic [TXW-1:0] resp_cur;
    logic [TXW-1:0] resp_first;

    // Acks in the ack_lat-th cycle of mem_req and records each transaction.
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (mem_req === 1'b1) begin
            req_cyc++;
            resp_cur = {mem_we, mem_addr, (mem_we ? mem_wdata : 512'b0)};
            if (req_cyc == 1) resp_first = resp_cur;
            if (req_cyc == ack_lat) begin
                check("req_hold", resp_cur, resp_first);
                act_q.push_back(resp_cur);
                if (mem_we) mem_lines[mem_addr] = mem_wdata;
                else        mem_rdata = mem_line_read(mem_addr);
                mem_ack = 1'b1;
            end
        end else begin
            req_cyc = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        CLR = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Flush = 1'b0;
        @(posedge clk);
        @(negedge clk);
        CLR = 1'b1;
        model_reset();
    endtask

    task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input string tag);
        int          ix;
        int          exp_stall;
        int          n;
        logic [25:0] ln;
        ix = int'(a[5+IDX_W:6]);
        ln = a[31:6];
        if (res_valid[ix] && res_line[ix] == ln) begin
            exp_stall = 0;
        end else begin
            if (res_valid[ix] && res_dirty[ix]) begin
                exp_q.push_back({1'b1, res_line[ix], gold_line(res_line[ix])});
                model_write_back(ix);
                exp_stall = 2 * ack_lat + 2;
            end else begin
                exp_stall = ack_lat + 1;
            end
            exp_q.push_back({1'b0, ln, 512'b0});
            res_valid[ix] = 1'b1;
            res_line[ix]  = ln;
            res_dirty[ix] = 1'b0;
        end
        @(negedge clk);
        MemRead = rd; MemWrite = wr; Addr = a; WData = wd;
        #1;
        n = 0;
        while (Stall !== 1'b0 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        check({tag, "_stall"}, n, exp_stall);
        if (rd && !wr) check({tag, "_rdata"}, RData, gold_word(a[31:2]));
        if (wr) begin
            gold[a[31:2]] = wd;
            res_dirty[ix] = 1'b1;
        end
        check_txns(tag);
    endtask

    task automatic do_flush(input string tag);
        int d;
        int n;
        d = 0;
        for (int ix = 0; ix < LINES; ix++) begin
            if (res_valid[ix] && res_dirty[ix]) begin
                exp_q.push_back({1'b1, res_line[ix], gold_line(res_line[ix])});
                model_write_back(ix);
                d++;
            end
        end
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0; Flush = 1'b1;
        @(posedge clk);
        #2 Flush = 1'b0;
        n = 0;
        while (FlushDone !== 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_done_at"}, n, LINES + d * (ack_lat + 1));
        check({tag, "_stall_at_done"}, Stall, 1'b0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, FlushDone, 1'b0);
        check_txns(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        int          op;

        // Reset values while CLR is held low.
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", RData, 32'h0);
        check("rst_stall", Stall, 1'b0);
        check("rst_flushdone", FlushDone, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 26'h0);
        check("rst_mem_wdata", mem_wdata, 512'h0);
        @(negedge clk);
        CLR = 1'b1;

        // Cold load, memory acks in the third request cycle.
        ack_lat = 3;
        access(1'b1, 1'b0, 32'h40, 32'h0, "cold_load");

        // Store miss then load hit of the same word.
        do_reset();
        ack_lat = 2;
        access(1'b0, 1'b1, 32'h44, 32'hDEAD_BEEF, "store_miss");
        access(1'b1, 1'b0, 32'h44, 32'h0, "load_after_store");

        // Conflicting line forces write-back of line 0x1, then fill of 0x9.
        access(1'b1, 1'b0, 32'h244, 32'h0, "evict_dirty");
        check("wb_word1", mem_lines[26'h1][63:32], 32'hDEAD_BEEF);

        // Dirty lines at index 1 and 5, flush, then both still hit.
        access(1'b0, 1'b1, 32'h44, $urandom, "dirty_idx1");
        access(1'b0, 1'b1, 32'h144, $urandom, "dirty_idx5");
        ack_lat = 3;
        do_flush("flush_two");
        access(1'b1, 1'b0, 32'h44, 32'h0, "post_flush_idx1");
        access(1'b1, 1'b0, 32'h144, 32'h0, "post_flush_idx5");
        do_flush("flush_clean");

        // Reset while a fill is outstanding.
        ack_lat = 1000;
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b0; Addr = 32'h1000;
        #1;
        check("clr_fill_stall", Stall, 1'b1);
        @(negedge clk);
        #1;
        check("clr_fill_req_up", mem_req, 1'b1);
        @(negedge clk);
        CLR = 1'b0; MemRead = 1'b0;
        @(posedge clk);
        #1;
        check("clr_fill_req_drop", mem_req, 1'b0);
        @(negedge clk);
        CLR = 1'b1;
        model_reset();
        act_q.delete();
        ack_lat = 2;
        access(1'b1, 1'b0, 32'h1000, 32'h0, "load_after_clr");

        // Read+write together on a hit behaves as a store and dirties the line.
        do_reset();
        access(1'b1, 1'b0, 32'h44, 32'h0, "rw_setup");
        access(1'b1, 1'b1, 32'h48, $urandom, "rw_hit");
        access(1'b1, 1'b0, 32'h48, 32'h0, "rw_readback");
        access(1'b1, 1'b0, 32'h244, 32'h0, "rw_evict");

        // Randomized mix of loads, stores, read+write, idles and flushes.
        for (int i = 0; i < 300; i++) begin
            ack_lat = $urandom_range(1, 4);
            if ($urandom_range(0, 15) == 0) begin
                do_flush("rnd_flush");
            end else begin
                a  = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 7)) << 6)
                   | (32'($urandom_range(0, 15)) << 2);
                op = $urandom_range(0, 3);
                case (op)
                    0, 1:    access(1'b1, 1'b0, a, 32'h0, "rnd_load");
                    2:       access(1'b0, 1'b1, a, $urandom, "rnd_store");
                    default: access(1'b1, 1'b1, a, $urandom, "rnd_rw");
                endcase
                if ($urandom_range(0, 7) == 0) begin
                    @(negedge clk);
                    MemRead = 1'b0; MemWrite = 1'b0;
                end
            end
        end
        do_flush("final_flush");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected $finish before time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dcache_wb_ctrl.md
# dcache_wb_ctrl

Direct-mapped, write-back, write-allocate data cache controller between the MEM stage of the phase-3 pipeline and the 512-bit-line data memory. It serves 32-bit loads and stores from a small line array and stalls the pipeline on misses. It moves whole 16-word lines to and from memory through a req/ack handshake. A flush port writes every dirty line back so that end-of-program memory dumps show final data.

## Interface
Parameters:
- IDX_W, 3, index bits; cache holds 2^IDX_W lines of 512 bits.
- TAG_W, 32-6-IDX_W, tag width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- CLR  in  1  reset, synchronous, active-low.
- MemRead  in  1  load request from MEM stage.
- MemWrite  in  1  store request from MEM stage.
- Addr  in  32  byte address; [1:0] ignored, [5:2] word, [5+IDX_W:6] index, [31:6+IDX_W] tag.
- WData  in  32  store data.
- RData  out  32  load data.
- Stall  out  1  freeze pipeline.
- Flush  in  1  pulse; start write-back of all dirty lines.
- FlushDone  out  1  one-cycle pulse when flush completes.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = line write, 0 = line read.
- mem_addr  out  26  line address, byte address [31:6].
- mem_wdata  out  512  line to write; word w is bits [32w+31:32w].
- mem_rdata  in  512  line returned by memory.
- mem_ack  in  1  one-cycle completion; read data is valid in the same cycle.

## Operation
- Per-line state: valid, dirty, tag, and 512-bit data. On reset, all valid and dirty bits clear; tag and data are don't-care.
- FSM states are IDLE, WB, FILL, FL_SCAN, and FL_WB. Reset puts the FSM in IDLE.
- IDLE behaviour:
  - A hit means valid and tag match.
  - Load hit: RData is the selected word, combinationally. Stall = 0.
  - Store hit: the word is written at the edge, and dirty is set. Stall = 0.
  - Miss with victim valid and dirty: Stall = 1 combinationally, next state is WB.
  - Miss otherwise: Stall = 1 combinationally, next state is FILL.
  - If MemRead and MemWrite are both high, the access is treated as a store.
  - With no access, RData = 0.
- WB: mem_req = 1, mem_we = 1, mem_addr = {victim tag, index}, mem_wdata = victim line. On mem_ack, clear dirty and go to FILL.
- FILL: mem_req = 1, mem_we = 0, mem_addr = Addr[31:6]. On mem_ack, load the line, set valid = 1, dirty = 0, store the new tag, and go to IDLE. The access is replayed in IDLE and hits.
- Stall = 1 in WB, FILL, FL_SCAN, and FL_WB.
- Flush is sampled only in IDLE when no miss is pending. If Flush and an access occur in the same cycle, the access is served first and Flush is retried by the requester.
- Flush sequence:
  - FL_SCAN walks a line counter from 0 to 2^IDX_W-1, one line per cycle.
  - A dirty line goes to FL_WB, which is the same handshake as WB. On ack it clears dirty and returns to FL_SCAN at the next line.
  - After the last line, FlushDone pulses for 1 cycle and the FSM returns to IDLE.
  - Valid bits are kept.
- mem_req, mem_we, mem_addr, and mem_wdata hold stable from the cycle mem_req rises until mem_ack. mem_ack is ignored when mem_req = 0.
- Reset in any state:
  - The next state is IDLE and mem_req drops at the following edge.
  - All lines are invalidated, and dirty data is lost.
  - FlushDone is not pulsed.

## Timing
- Reset values: RData 0, Stall 0, FlushDone 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0.
- Hit: 0 stall cycles. Load data is valid in the same cycle, and a store commits at the end of that cycle.
- Clean miss with ack latency L (ack L cycles after req rises, L ≥ 1): Stall is high for L+1 cycles. The access completes in the cycle after the fill ack.
- Dirty miss with ack latencies L1 and L2: Stall is high for L1+L2+2 cycles.
- Flush with no dirty lines: FlushDone rises 2^IDX_W cycles after Flush is sampled.
- Flush with d dirty lines, each with ack latency L: FlushDone rises 2^IDX_W + d·(L+1) cycles after Flush is sampled.
- Back-to-back hits, including a store then a load of the same word, return the new data with no bubble.

## Test plan
- Reset, then load from 0x40. Required: Stall = 1 and mem_req = 1 with mem_we = 0, mem_addr = 0x1. With memory acking after 3 cycles, Stall is high for 4 cycles, then RData = the memory word at 0x40.
- Store 0xDEADBEEF to 0x44, then load from 0x44. Required: the store causes a miss and fill; the following load hits with RData = 0xDEADBEEF and Stall = 0; the line is marked dirty.
- Store to 0x44, then load from 0x44 + 2^(6+IDX_W) (0x244 for IDX_W = 3). Required: a WB handshake with mem_addr = 0x1 and mem_wdata bits [63:32] = 0xDEADBEEF, followed by a FILL with mem_addr = 0x9.
- Dirty lines at index 1 and index 5, then pulse Flush. Required: exactly two write transactions, in index order 1 then 5, FlushDone for 1 cycle, and afterwards loads to both lines hit.
- Assert CLR low during FILL before mem_ack arrives. Required: mem_req is 0 on the next cycle, and a later load from the same address misses.
- MemRead and MemWrite both high on a hit. Required: treated as a store, the line becomes dirty, and Stall = 0.
